// File: rtl/shift_register_seq_pkg.sv
// Shared definitions for the multi-mode shift register: operation codes and
// the controller state encoding.
package shift_register_seq_pkg;

  localparam logic [2:0] MODE_LOAD = 3'd0;
  localparam logic [2:0] MODE_SLL  = 3'd1;
  localparam logic [2:0] MODE_SRL  = 3'd2;
  localparam logic [2:0] MODE_SRA  = 3'd3;
  localparam logic [2:0] MODE_ROL  = 3'd4;
  localparam logic [2:0] MODE_ROR  = 3'd5;
  localparam logic [2:0] MODE_SLI  = 3'd6;
  localparam logic [2:0] MODE_CLR  = 3'd7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/shift_register_seq_if.sv
// Request/finish handshake and data bus of the shift register. The controller
// side drives the operation; the register side returns status and contents.
interface shift_register_seq_if #(
  parameter int Width  = 32,
  parameter int ShamtW = $clog2(Width)
);
  logic              req;
  logic              fin;
  logic [2:0]        mode;
  logic [ShamtW-1:0] shamt;
  logic              serialIn;
  logic [Width-1:0]  in;
  logic [Width-1:0]  out;
  logic              carryOut;
  logic              busy;

  modport master (
    output req, mode, shamt, serialIn, in,
    input  fin, out, carryOut, busy
  );

  modport slave (
    input  req, mode, shamt, serialIn, in,
    output fin, out, carryOut, busy
  );
endinterface

// File: rtl/shift_register_seq_shift_step.sv
// Single-bit shift/rotate step. Produces the value after one step in the given
// mode and the bit that left the word. Non-shift modes pass the value through.
module shift_register_seq_shift_step
  import shift_register_seq_pkg::*;
#(
  parameter int Width = 32
) (
  input  logic [Width-1:0] val_i,
  input  logic [2:0]       mode_i,
  input  logic             fill_i,
  output logic [Width-1:0] val_o,
  output logic             carry_o
);

  // One-step result for each shift flavour; the carry is the bit pushed out.
  always_comb begin
    val_o   = val_i;
    carry_o = 1'b0;
    case (mode_i)
      MODE_SLL: {carry_o, val_o} = {val_i, 1'b0};
      MODE_SLI: {carry_o, val_o} = {val_i, fill_i};
      MODE_ROL: begin
        val_o   = {val_i[Width-2:0], val_i[Width-1]};
        carry_o = val_i[Width-1];
      end
      MODE_SRL: {val_o, carry_o} = {1'b0, val_i};
      MODE_SRA: {val_o, carry_o} = {val_i[Width-1], val_i};
      MODE_ROR: begin
        val_o   = {val_i[0], val_i[Width-1:1]};
        carry_o = val_i[0];
      end
      default: begin
        val_o   = val_i;
        carry_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/shift_register_seq.sv
// Multi-mode shift register with a four-phase req/fin handshake. One operation
// is captured per handshake; multi-bit shifts run one bit per clock so the
// intermediate values are visible on out.
module shift_register_seq
  import shift_register_seq_pkg::*;
#(
  parameter int Width  = 32,
  parameter int ShamtW = $clog2(Width)
) (
  input  logic                 clk,
  input  logic                 rstN,
  shift_register_seq_if.slave  bus
);

  state_t            state_q, state_d;
  logic [ShamtW-1:0] cnt_q, cnt_d;
  logic [Width-1:0]  out_q, out_d;
  logic              carry_q, carry_d;
  logic [2:0]        mode_q, mode_d;
  logic              fill_q, fill_d;

  logic [Width-1:0]  step_val;
  logic              step_carry;

  shift_register_seq_shift_step #(
    .Width (Width)
  ) u_shift_step (
    .val_i   (out_q),
    .mode_i  (mode_q),
    .fill_i  (fill_q),
    .val_o   (step_val),
    .carry_o (step_carry)
  );

  // Next-state and datapath: capture in IDLE, step in SHIFT, wait for req low in DONE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    carry_d = carry_q;
    mode_d  = mode_q;
    fill_d  = fill_q;
    case (state_q)
      IDLE: begin
        if (bus.req) begin
          mode_d = bus.mode;
          fill_d = bus.serialIn;
          if (bus.mode == MODE_LOAD) begin
            out_d   = bus.in;
            carry_d = 1'b0;
            state_d = DONE;
          end else if (bus.mode == MODE_CLR) begin
            out_d   = '0;
            carry_d = 1'b0;
            state_d = DONE;
          end else if (bus.shamt == '0) begin
            // Zero-length shift: contents untouched, carry cleared.
            carry_d = 1'b0;
            state_d = DONE;
          end else begin
            cnt_d   = bus.shamt;
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        out_d   = step_val;
        carry_d = step_carry;
        cnt_d   = cnt_q - 1'b1;
        // Counter stops at 1, so it can never wrap below zero.
        if (cnt_q == ShamtW'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (!bus.req) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and visible register state; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      out_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      carry_q <= carry_d;
    end
  end

  // Captured operation parameters; only meaningful while SHIFT, so no reset.
  always_ff @(posedge clk) begin
    mode_q <= mode_d;
    fill_q <= fill_d;
  end

  assign bus.fin      = (state_q == DONE);
  assign bus.busy     = (state_q != IDLE);
  assign bus.out      = out_q;
  assign bus.carryOut = carry_q;

endmodule
